// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between an issue stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, kill, funct3, a, b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, a, b, rd_in,
        output busy, done, result, rd_out
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M multiply/divide unit. 32-step shift-add multiply and
//               restoring divide on operand magnitudes, sign fixed up in FIN.
//               Define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_neg;
    logic [4:0]  r_rd;
    logic        r_done;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic        w_accept;
    logic        w_signed_a;
    logic        w_signed_b;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_neg_in;
    logic        w_div_zero;
    logic        w_skip;
    logic [32:0] w_add;
    logic [63:0] w_mul_step;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_div_step;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fin_val;

    assign w_accept   = (r_state == c_IDLE) && bus.start && !bus.kill;
    assign w_signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                        (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                        (bus.funct3 == 3'b110);
    assign w_sign_a   = w_signed_a && bus.a[31];
    assign w_sign_b   = w_signed_b && bus.b[31];
    assign w_a_mag    = w_sign_a ? (32'd0 - bus.a) : bus.a;
    assign w_b_mag    = w_sign_b ? (32'd0 - bus.b) : bus.b;
    // Remainder follows the dividend; every other result follows sign(a)^sign(b).
    assign w_neg_in   = (bus.funct3 == 3'b110) ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_div_zero = bus.funct3[2] && (bus.b == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
    assign w_skip = w_div_zero || !bus.funct3[2];
    assign w_prod = {32'd0, r_acc[31:0]} * {32'd0, r_b};
`else
    assign w_skip = w_div_zero;
    assign w_prod = r_acc;
`endif

    // Multiply: r_acc = {partial high, multiplier shifting out at bit 0}.
    assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_step = {w_add, r_acc[31:1]};

    // Divide: r_acc = {remainder, dividend/quotient}, shifted left each step.
    assign w_ge       = r_acc[63:31] >= {1'b0, r_b};
    assign w_diff     = r_acc[62:31] - r_b;
    assign w_div_step = w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

    assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
    assign w_quo    = r_neg ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem    = r_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_fin_val = w_rem;
        case (r_op)
            3'b000:                 w_fin_val = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_fin_val = w_prod_s[63:32];
            3'b100, 3'b101:         w_fin_val = w_quo;
            default:                w_fin_val = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip ? c_FIN : c_CALC;
                end
            end
            c_CALC: begin
                if (bus.kill) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == 6'd31) begin
                    w_state_nxt = c_FIN;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= 6'd0;
            r_op     <= 3'd0;
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_neg    <= 1'b0;
            r_rd     <= 5'd0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_rd_out <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.funct3;
                        r_rd  <= bus.rd_in;
                        r_b   <= w_b_mag;
                        r_cnt <= 6'd0;
                        // Divide-by-zero preloads {rem, quo} = {a, all-ones}.
                        r_neg <= w_div_zero ? 1'b0 : w_neg_in;
                        r_acc <= w_div_zero ? {bus.a, 32'hFFFF_FFFF} : {32'd0, w_a_mag};
                    end
                end
                c_CALC: begin
                    if (bus.kill) begin
                        r_cnt <= 6'd0;
                    end else begin
                        r_acc <= r_op[2] ? w_div_step : w_mul_step;
                        r_cnt <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
                    end
                end
                c_FIN: begin
                    if (!bus.kill) begin
                        r_result <= w_fin_val;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                    end
                end
                default: r_cnt <= 6'd0;
            endcase
        end
    end

    assign bus.busy   = (r_state != c_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit. Latency is
//               counted with the accepting edge as edge 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int c_MUL_LAT = 2;
`else
    localparam int c_MUL_LAT = 34;
`endif
    localparam int c_DIV_LAT = 34;
    localparam int c_DZ_LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_unit_if bus ();

    muldiv_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op, waits for done (bounded), checks latency/result/tag.
    // back2back leaves the bench in the done cycle for an immediate reissue.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input bit back2back);
        int edges;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = av;
        bus.b      = bv;
        bus.rd_in  = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.rd_in = ~rd;
        edges     = 1;
        while (!bus.done && edges < 40) begin
            if (edges == 3) begin
                bus.start  = 1'b1;
                bus.funct3 = ~f;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        check_eq({tag, "_lat"}, edges, exp_lat);
        check_eq({tag, "_res"}, bus.result, exp);
        check_eq({tag, "_rd"}, {27'd0, bus.rd_out}, {27'd0, rd});
        if (!back2back) begin
            @(posedge clk); #1;
            check_eq({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    task automatic watch_no_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.rd_in  = 5'd0;

        // Reset with start asserted: must stay idle.
        rst        = 1'b0;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.a      = 32'd3;
        bus.b      = 32'd3;
        bus.rd_in  = 5'd9;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done",   {31'd0, bus.done}, 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_rd",     {27'd0, bus.rd_out}, 32'd0);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_idle", {31'd0, bus.busy}, 32'd0);

        run_op("mul_7x6",    3'b000, 32'd7,         32'd6,         5'd5,  32'h0000_002A, c_MUL_LAT, 1'b0);
        run_op("mul_neg",    3'b000, 32'hFFFF_FFFD, 32'd5,         5'd1,  32'hFFFF_FFF1, c_MUL_LAT, 1'b0);
        run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, c_MUL_LAT, 1'b0);
        run_op("mulhu_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, c_MUL_LAT, 1'b0);
        run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, c_MUL_LAT, 1'b0);
        run_op("mulhu_big",  3'b011, 32'h8000_0000, 32'd4,         5'd6,  32'h0000_0002, c_MUL_LAT, 1'b0);
        run_op("mulh_min",   3'b001, 32'h8000_0000, 32'd2,         5'd7,  32'hFFFF_FFFF, c_MUL_LAT, 1'b0);
        run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, c_DIV_LAT, 1'b0);
        run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, c_DIV_LAT, 1'b0);
        run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        c_DIV_LAT, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         5'd11, 32'd2,         c_DIV_LAT, 1'b0);
        run_op("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, c_DIV_LAT, 1'b0);
        run_op("rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1,         c_DIV_LAT, 1'b0);
        run_op("divu_by0",   3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, c_DZ_LAT,  1'b0);
        run_op("rem_by0",    3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         c_DZ_LAT,  1'b0);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, c_DIV_LAT, 1'b1);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         c_DIV_LAT, 1'b0);

        // Kill alongside start in IDLE discards the request.
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        bus.funct3 = 3'b101;
        bus.a      = 32'd9;
        bus.b      = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check_eq("kill_start_busy", {31'd0, bus.busy}, 32'd0);

        // Reset at edge 10 of a DIV.
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.a      = 32'd1000;
        bus.b      = 32'd3;
        bus.rd_in  = 5'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        check_eq("midrst_result", bus.result, 32'd0);
        check_eq("midrst_rd",     {27'd0, bus.rd_out}, 32'd0);
        watch_no_done("midrst_nodone");

        // Leave a known result, then kill at edge 10 of a second DIV.
        run_op("mul_seed", 3'b000, 32'd7, 32'd6, 5'd5, 32'h0000_002A, c_MUL_LAT, 1'b0);
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.a      = 32'd1000;
        bus.b      = 32'd3;
        bus.rd_in  = 5'd21;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check_eq("kill_busy",   {31'd0, bus.busy}, 32'd0);
        check_eq("kill_result", bus.result, 32'h0000_002A);
        check_eq("kill_rd",     {27'd0, bus.rd_out}, 32'd5);
        watch_no_done("kill_nodone");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
